// File: rtl/spi_data_fifo.sv
// rtl/spi_data_fifo.sv - SPI staging FIFO with occupancy flags, sticky errors and strobe mode; SPI_FIFO_FWFT_EN selects first-word-fall-through reads
module spi_data_fifo #(
    parameter int WORD_SIZE     = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int EDGE_MODE     = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       write,
    input  logic                       read,
    input  logic                       clear_err,
    input  logic [WORD_SIZE-1:0]       data_in,
    output logic [WORD_SIZE-1:0]       data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       buffer_full,
    output logic                       buffer_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_THRESH);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          write_q, read_q;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_req, rd_req, wr_acc, rd_acc;
`ifndef SPI_FIFO_FWFT_EN
    logic [WORD_SIZE-1:0] dout_q, dout_d;
`endif

    // Request qualification, acceptance, next pointers/count/flags
    always_comb begin
        wr_req = (EDGE_MODE != 0) ? (write & ~write_q) : write;
        rd_req = (EDGE_MODE != 0) ? (read & ~read_q) : read;
        // A read frees the head slot, so a write into a full FIFO is accepted alongside it
        rd_acc = rd_req && (count_q != '0);
        wr_acc = wr_req && ((count_q != FULL_CNT) || rd_acc);

        wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        full_d   = (count_d == FULL_CNT);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AFULL_CNT);
        aempty_d = (count_d <= AEMPTY_CNT);

        // Set wins over clear when both happen in one cycle
        ovf_d = (wr_req && !wr_acc) || (ovf_q && !clear_err);
        udf_d = (rd_req && !rd_acc) || (udf_q && !clear_err);
`ifndef SPI_FIFO_FWFT_EN
        dout_d = rd_acc ? mem[rd_ptr_q] : dout_q;
`endif
    end

    // Control state with asynchronous active-high reset
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
`ifndef SPI_FIFO_FWFT_EN
            dout_q   <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            write_q  <= write;
            read_q   <= read;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
`ifndef SPI_FIFO_FWFT_EN
            dout_q   <= dout_d;
`endif
        end
    end

    // Storage array; contents are not reset, pointers alone define validity
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef SPI_FIFO_FWFT_EN
    assign data_out = (count_q == '0) ? '0 : mem[rd_ptr_q];
`else
    assign data_out = dout_q;
`endif

    assign count        = count_q;
    assign buffer_full  = full_q;
    assign buffer_empty = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule

// File: doc/spi_data_fifo.md
Name: spi_data_fifo

Overview:
- Parametrised synchronous FIFO for SPI transmit and receive staging. Successor to the fixed-behaviour data buffer.
- Adds occupancy count, almost-full and almost-empty thresholds, an empty flag, and sticky overflow/underflow flags with a clear input.
- Adds a strobe mode that selects level-per-cycle operation or one operation per strobe pulse.
- Sits between the SPI shift engine and the host-side register interface.

Parameters:
- WORD_SIZE, 8, data width in bits (>=1).
- DEPTH, 4, number of entries; power of two, >=2.
- AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 1, almost_empty asserts when count <= AEMPTY_THRESH.
- EDGE_MODE, 0:
  - 0: write/read sampled every clk they are high.
  - 1: one operation per rising edge of the write/read strobe.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rstn  in  1  asynchronous, active-high reset (1 = reset asserted).
- write  in  1  write request.
- read  in  1  read request.
- clear_err  in  1  clears overflow and underflow.
- data_in  in  WORD_SIZE  write data.
- data_out  out  WORD_SIZE  read data.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- buffer_full  out  1  count == DEPTH.
- buffer_empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- overflow  out  1  sticky; a write was dropped.
- underflow  out  1  sticky; a read was rejected.

Behaviour:
- Reset (rstn=1, asynchronous):
  - Pointers, count, data_out and strobe-history registers = 0.
  - buffer_empty=1, almost_empty=1, buffer_full=0, almost_full=0, overflow=0, underflow=0.
  - Storage array is not reset.
  - Reset asserted mid-operation discards all contents immediately. The first operation is accepted on the first clk edge after deassertion.
- Effective requests:
  - EDGE_MODE=0: wr_req=write, rd_req=read.
  - EDGE_MODE=1: wr_req = write & ~write_q and rd_req = read & ~read_q, where write_q/read_q are registered copies of the strobes. A strobe held high for N cycles produces exactly one operation.
- Write: if wr_req and not full, data_in is stored at the write pointer and the pointer increments modulo DEPTH. If wr_req and full, the write is dropped (unless a read is accepted in the same cycle, see below) and overflow is set.
- Read: if rd_req and not empty, the head entry is registered into data_out and the read pointer increments modulo DEPTH. Latency is 1 cycle: data_out is valid on the edge after acceptance. If rd_req and empty, data_out holds and underflow is set.
- data_out holds its last value when no read is accepted.
- Simultaneous wr_req and rd_req:
  - Not empty and not full: both accepted; count unchanged.
  - Full: read accepted, and the write is also accepted into the freed slot; count stays DEPTH; no overflow.
  - Empty: write accepted, read rejected, underflow set; count becomes 1.
- count: +1 on write-only accept, -1 on read-only accept, unchanged otherwise. Never exceeds DEPTH or goes below 0.
- All flags are registered and derived from next count, so they are valid in the same cycle as count.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not pointer equality.
- Sticky flags:
  - Cleared by clear_err=1.
  - If clear_err and a new error occur in the same cycle, the flag is set (set wins).

Optional Feature:
- Macro SPI_FIFO_FWFT_EN.
- Defined: first-word-fall-through.
  - data_out continuously shows the head entry (combinational from storage at the read pointer).
  - It shows 0 when empty.
  - rd_req pops the entry; read latency is 0.
  - Simultaneous write+read when empty is still rejected for the read (underflow set).
- Undefined: registered 1-cycle read latency as described in Behaviour.

Test Plan (WORD_SIZE=8, DEPTH=4 unless stated):
- Reset then write 51, 14, 128 (one cycle each, EDGE_MODE=0), then 3 single-cycle reads:
  - data_out = 51, 14, 128 on successive edges.
  - count 3 -> 0.
  - buffer_empty=1 and underflow=0 at end.
- Write 5 words 1..5 with no reads:
  - count=4, buffer_full=1, almost_full=1 after the 3rd word.
  - overflow=1 after the 5th; word 5 is lost.
  - Reading 4 times returns 1, 2, 3, 4.
- Read when empty: data_out holds its previous value (e.g. 128) and underflow=1. Then pulse clear_err -> underflow=0.
- Fill to 4, then assert write=1 (data 0xAA) and read=1 together for one cycle: data_out=head value, count stays 4, overflow=0. 0xAA is returned 4th in the subsequent drain.
- EDGE_MODE=1 with write held high for 10 cycles (data 0x33): count=1 only. Hold read high for 10 cycles: exactly one read, underflow=0.
- Assert rstn=1 mid-stream with count=3: all outputs return to reset values asynchronously, before the next clk edge. After release, a write of 0x7E followed by a read returns 0x7E.
